// File: rtl/arm_multicycle_controller.sv
// Multicycle sequencer for the ARM-subset core: walks each instruction through
// fetch/decode/execute/memory/writeback and gates architectural writes by condition.
module arm_multicycle_controller #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic       RegWrite,
  output logic [1:0] ALUControl,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t     state, next_state;
  logic [3:0] flags;
  logic       cond_ex_now, cond_ex_q;
  logic [3:0] cmd;
  logic       cmd_ok;
  logic [1:0] alu_op;
  logic       reg_w, mem_w, branch, pcs;
  logic       flag_n, flag_z, flag_c, flag_v;

  assign cmd = Funct[4:1];
  assign {flag_n, flag_z, flag_c, flag_v} = flags;

  always_comb begin
    cmd_ok = 1'b1;
    alu_op = 2'b00;
    case (cmd)
      4'b0100: alu_op = 2'b00;
      4'b0010: alu_op = 2'b01;
      4'b0000: alu_op = 2'b10;
      4'b1100: alu_op = 2'b11;
      default: cmd_ok = 1'b0;
    endcase
  end

  always_comb begin
    cond_ex_now = 1'b0;
    case (Cond)
      4'b0000: cond_ex_now = flag_z;
      4'b0001: cond_ex_now = ~flag_z;
      4'b0010: cond_ex_now = flag_c;
      4'b0011: cond_ex_now = ~flag_c;
      4'b0100: cond_ex_now = flag_n;
      4'b0101: cond_ex_now = ~flag_n;
      4'b0110: cond_ex_now = flag_v;
      4'b0111: cond_ex_now = ~flag_v;
      4'b1000: cond_ex_now = flag_c & ~flag_z;
      4'b1001: cond_ex_now = ~flag_c | flag_z;
      4'b1010: cond_ex_now = (flag_n == flag_v);
      4'b1011: cond_ex_now = (flag_n != flag_v);
      4'b1100: cond_ex_now = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_ex_now = flag_z | (flag_n != flag_v);
      4'b1110: cond_ex_now = 1'b1;
      default: cond_ex_now = 1'b0;
    endcase
  end

  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:   next_state = DECODE;
      DECODE: begin
        case (Op)
          2'b01:   next_state = MEMADR;
          2'b00:   next_state = Funct[5] ? EXECI : EXECR;
          2'b10:   next_state = BRANCH;
          default: next_state = FETCH;
        endcase
      end
      MEMADR:  next_state = Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD: next_state = MEMWB;
      EXECR:   next_state = ALUWB;
      EXECI:   next_state = ALUWB;
      default: next_state = FETCH;
    endcase
  end

  // Condition is latched at DECODE so an instruction's own flag update cannot
  // change whether its writeback happens; it only affects later instructions.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= FETCH;
      flags     <= RESET_FLAGS;
      cond_ex_q <= 1'b0;
    end else begin
      state <= next_state;
      if (state == DECODE) cond_ex_q <= cond_ex_now;
      if ((state == EXECR || state == EXECI) && cond_ex_q && cmd_ok && Funct[0]) begin
        flags[3:2] <= ALUFlags[3:2];
        if (!alu_op[1]) flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 2'b00;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    case (state)
      FETCH, DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR:   ALUSrcB = 2'b01;
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
      end
      EXECR:    ALUControl = alu_op;
      EXECI: begin
        ALUSrcB    = 2'b01;
        ALUControl = alu_op;
      end
      ALUWB:    reg_w = cmd_ok;
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are qualified by Reset so nothing architectural moves while it is held.
  assign pcs      = (reg_w && (Rd == 4'd15)) || branch;
  assign PCWrite  = Reset & ((state == FETCH) | (pcs & cond_ex_q));
  assign IRWrite  = Reset & (state == FETCH);
  assign RegWrite = Reset & reg_w & cond_ex_q & (Rd != 4'd15);
  assign MemWrite = Reset & mem_w & cond_ex_q;
  assign ImmSrc   = Op;
  assign RegSrc   = {Op == 2'b01, Op == 2'b10};
  assign State    = state;

endmodule

// File: tb/tb_arm_multicycle_controller.sv
// Bench for arm_multicycle_controller: per-instruction expected output plan from a
// flag/condition model, checked every cycle, plus directed literal checks.
module tb_arm_multicycle_controller;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [3:0] Cond = 4'd0;
  logic [1:0] Op = 2'd0;
  logic [5:0] Funct = 6'd0;
  logic [3:0] Rd = 4'd0;
  logic [3:0] ALUFlags = 4'd0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
  logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;
  logic [3:0] State;

  arm_multicycle_controller #(.RESET_FLAGS(4'b0000)) dut (
    .Clk(Clk), .Reset(Reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .RegWrite(RegWrite), .ALUControl(ALUControl),
    .State(State)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       pcw;
    logic       adrsrc;
    logic       memw;
    logic       irw;
    logic [1:0] ressrc;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] imm;
    logic [1:0] regsrc;
    logic       regw;
    logic [1:0] aluc;
    logic [3:0] st;
  } out_t;

  out_t act;
  assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ImmSrc, RegSrc, RegWrite, ALUControl, State};

  int         total = 0;
  int         bad = 0;
  out_t       exp_o;
  logic       exp_vld = 1'b0;
  logic [3:0] mflags = 4'b0000;
  out_t       plan[$];
  int         exec_idx;
  out_t       obs[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge Clk) if (exp_vld) chk("cycle_outputs", 32'(act), 32'(exp_o));

  // ARM condition semantics: even codes test a predicate, odd codes invert it.
  function automatic logic cpass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, b;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cf;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cf & ~z;
      3'd5: b = (n == v);
      3'd6: b = ~z & (n == v);
      default: b = 1'b1;
    endcase
    return c[0] ? ~b : b;
  endfunction

  task automatic alu_table(input logic [3:0] cmd, output logic ok, output logic [1:0] aop);
    ok = 1'b1;
    aop = 2'b00;
    if (cmd == 4'b0100) aop = 2'b00;
    else if (cmd == 4'b0010) aop = 2'b01;
    else if (cmd == 4'b0000) aop = 2'b10;
    else if (cmd == 4'b1100) aop = 2'b11;
    else ok = 1'b0;
  endtask

  function automatic out_t blank(input logic [1:0] op, input logic [3:0] st);
    out_t o;
    o = '0;
    o.imm = op;
    o.regsrc = {op == 2'b01, op == 2'b10};
    o.st = st;
    return o;
  endfunction

  task automatic build_plan(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd,
                            input logic pass);
    out_t o;
    logic ok;
    logic [1:0] aop;
    plan.delete();
    exec_idx = -1;
    o = blank(op, 4'd0); o.pcw = 1; o.irw = 1; o.srca = 1; o.srcb = 2; o.ressrc = 2;
    plan.push_back(o);
    o = blank(op, 4'd1); o.srca = 1; o.srcb = 2; o.ressrc = 2;
    plan.push_back(o);
    case (op)
      2'b01: begin
        o = blank(op, 4'd2); o.srcb = 1; plan.push_back(o);
        if (fn[0]) begin
          o = blank(op, 4'd3); o.adrsrc = 1; plan.push_back(o);
          o = blank(op, 4'd4); o.ressrc = 1;
          o.regw = pass && rd != 15; o.pcw = pass && rd == 15;
          plan.push_back(o);
        end else begin
          o = blank(op, 4'd5); o.adrsrc = 1; o.memw = pass; plan.push_back(o);
        end
      end
      2'b00: begin
        alu_table(fn[4:1], ok, aop);
        o = blank(op, fn[5] ? 4'd7 : 4'd6);
        o.srcb = fn[5] ? 2'd1 : 2'd0;
        o.aluc = ok ? aop : 2'b00;
        exec_idx = 2;
        plan.push_back(o);
        o = blank(op, 4'd8);
        o.regw = ok && pass && rd != 15; o.pcw = ok && pass && rd == 15;
        plan.push_back(o);
      end
      2'b10: begin
        o = blank(op, 4'd9); o.srcb = 1; o.ressrc = 2; o.pcw = pass; plan.push_back(o);
      end
      default: ;
    endcase
  endtask

  task automatic step(input int k, input logic [3:0] af);
    ALUFlags = (k == exec_idx) ? af : 4'($urandom);
    exp_o = plan[k];
    exp_vld = 1'b1;
    @(negedge Clk);
    obs[k] = act;
    @(posedge Clk);
    #1;
  endtask

  task automatic model_flags(input logic [1:0] op, input logic [5:0] fn, input logic pass,
                             input logic [3:0] af);
    logic ok;
    logic [1:0] aop;
    alu_table(fn[4:1], ok, aop);
    if (op == 2'b00 && pass && ok && fn[0]) begin
      mflags[3:2] = af[3:2];
      if (aop == 2'b00 || aop == 2'b01) mflags[1:0] = af[1:0];
    end
  endtask

  // Runs one instruction starting in FETCH; leaves the DUT in the next FETCH.
  task automatic run(input logic [3:0] c, input logic [1:0] op, input logic [5:0] fn,
                     input logic [3:0] rd, input logic [3:0] af);
    logic pass;
    pass = cpass(c, mflags);
    build_plan(op, fn, rd, pass);
    Cond = c; Op = op; Funct = fn; Rd = rd;
    for (int k = 0; k < plan.size(); k++) step(k, af);
    model_flags(op, fn, pass, af);
  endtask

  task automatic reset_in_exec;
    out_t r;
    build_plan(2'b00, 6'b001001, 4'd2, cpass(4'hE, mflags));
    Cond = 4'hE; Op = 2'b00; Funct = 6'b001001; Rd = 4'd2;
    step(0, 4'b1111);
    step(1, 4'b1111);
    ALUFlags = 4'b1111;
    exp_o = plan[2];
    #2 Reset = 1'b0;
    r = blank(2'b00, 4'd0); r.srca = 1; r.srcb = 2; r.ressrc = 2;
    exp_o = r;
    #1;
    chk("rst_state", 32'(State), 32'd0);
    chk("rst_enables", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'd0);
    @(negedge Clk);
    @(posedge Clk);
    #1;
    chk("rst_hold_regwrite", 32'(RegWrite), 32'd0);
    Reset = 1'b1;
    mflags = 4'b0000;
  endtask

  initial begin
    #1;
    chk("por_state", 32'(State), 32'd0);
    chk("por_enables", 32'({PCWrite, IRWrite, RegWrite, MemWrite}), 32'd0);
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Reset = 1'b1;

    // ADDS R1 with ALUFlags=0100 -> Z set
    run(4'hE, 2'b00, 6'b001001, 4'd1, 4'b0100);
    chk("adds_states", 32'({obs[0].st, obs[1].st, obs[2].st, obs[3].st}), 32'h0168);
    chk("adds_aluc", 32'(obs[2].aluc), 32'd0);
    chk("adds_regw", 32'({obs[0].regw, obs[1].regw, obs[2].regw, obs[3].regw}), 32'b0001);

    run(4'h0, 2'b10, 6'b100000, 4'd0, 4'b0000);
    chk("beq_taken", 32'(obs[2].pcw), 32'd1);
    chk("beq_states", 32'({obs[0].st, obs[1].st, obs[2].st}), 32'h019);
    run(4'h1, 2'b10, 6'b100000, 4'd0, 4'b0000);
    chk("bne_not_taken", 32'(obs[2].pcw), 32'd0);

    run(4'hE, 2'b01, 6'b011001, 4'd3, 4'b0000);
    chk("ldr_states", 32'({obs[0].st, obs[1].st, obs[2].st, obs[3].st, obs[4].st}), 32'h01234);
    chk("ldr_memread_adr", 32'(obs[3].adrsrc), 32'd1);
    chk("ldr_memwb", 32'({obs[4].ressrc, obs[4].regw}), 32'b011);

    run(4'hE, 2'b01, 6'b011000, 4'd3, 4'b0000);
    chk("str_memw", 32'({obs[0].memw, obs[1].memw, obs[2].memw, obs[3].memw}), 32'b0001);
    chk("str_state", 32'(obs[3].st), 32'd5);

    run(4'hE, 2'b00, 6'b001000, 4'd15, 4'b0000);
    chk("add_pc_dest", 32'({obs[3].pcw, obs[3].regw}), 32'b10);

    // clear Z, then ORRS EQ must be suppressed and leave flags alone
    run(4'hE, 2'b00, 6'b001001, 4'd1, 4'b0000);
    run(4'h0, 2'b00, 6'b011001, 4'd4, 4'b0100);
    chk("orrs_suppressed", 32'(obs[3].regw), 32'd0);
    run(4'h0, 2'b10, 6'b100000, 4'd0, 4'b0000);
    chk("beq_after_orrs", 32'(obs[2].pcw), 32'd0);

    // flags 0011, then ANDS with ALUFlags 1011 -> 1011 (CV kept)
    run(4'hE, 2'b00, 6'b001001, 4'd1, 4'b0011);
    run(4'hE, 2'b00, 6'b000001, 4'd5, 4'b1011);
    run(4'h4, 2'b10, 6'b100000, 4'd0, 4'b0000);
    chk("bmi_after_ands", 32'(obs[2].pcw), 32'd1);
    run(4'h2, 2'b10, 6'b100000, 4'd0, 4'b0000);
    chk("bcs_after_ands", 32'(obs[2].pcw), 32'd1);
    run(4'h6, 2'b10, 6'b100000, 4'd0, 4'b0000);
    chk("bvs_after_ands", 32'(obs[2].pcw), 32'd1);

    // set Z, reset inside EXECR, flags must come back as 0000
    run(4'hE, 2'b00, 6'b001001, 4'd1, 4'b0100);
    reset_in_exec();
    run(4'h0, 2'b10, 6'b100000, 4'd0, 4'b0000);
    chk("post_rst_fetch", 32'({obs[0].st, obs[0].irw}), 32'b00001);
    chk("post_rst_decode", 32'({obs[1].st, obs[1].irw}), 32'b00010);
    chk("beq_after_rst", 32'(obs[2].pcw), 32'd0);

    for (int i = 0; i < 400; i++) begin
      logic [3:0] c, rd, af;
      logic [1:0] op;
      logic [5:0] fn;
      c  = ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom);
      op = 2'($urandom);
      fn = 6'($urandom);
      if ($urandom_range(0, 1) == 0) fn[4:1] = 4'({$urandom_range(0, 3)} == 0 ? 4'b0100 :
                                                  {$urandom_range(0, 2)} == 0 ? 4'b0010 :
                                                  {$urandom_range(0, 1)} == 0 ? 4'b0000 : 4'b1100);
      rd = ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom);
      af = 4'($urandom);
      run(c, op, fn, rd, af);
    end

    exp_vld = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
